// File: rtl/lsu_mw.sv
// ---------------------------------------------------------------------------
// lsu_mw -- load/store unit for the MW stage of the 3-stage RV32I pipeline.
//
// Takes a load or store from the MW pipeline register and runs one req/ack
// transaction on the data bus. It formats the byte enables and the
// lane-replicated write data, and sign- or zero-extends the load data. While
// an access is in flight, Stall_MW holds the MW register. The access
// completes with a single-cycle lsu_valid pulse.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   When defined, a misaligned H/HU/W access skips the bus and completes
//   with lsu_misalign=1. When undefined, lsu_misalign is tied 0 and the
//   low address bits a halfword/word access does not use are ignored.
//
// Parameters:
//   TIMEOUT_CYCLES  REQ cycles without dbus_ack before the access is aborted
//                   with a bus error (1..65535).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   mem_rd_MW       MW stage holds a load
//   mem_wr_MW       MW stage holds a store
//   funct3_MW       size/sign: 000=B 001=H 010=W 100=BU 101=HU (others = W)
//   ALUResult_MW    effective byte address
//   rdata2_MW       store data
//   Stall_MW        hold MW register and upstream stages (combinational)
//   lsu_rdata       extended load result, valid with lsu_valid
//   lsu_valid       one-cycle completion pulse
//   lsu_buserr      with lsu_valid: access timed out
//   lsu_misalign    with lsu_valid: misaligned access (macro build only)
//   dbus_*          data bus master; read data is valid with dbus_ack
// ---------------------------------------------------------------------------
module lsu_mw #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd_MW,
  input  logic        mem_wr_MW,
  input  logic [2:0]  funct3_MW,
  input  logic [31:0] ALUResult_MW,
  input  logic [31:0] rdata2_MW,
  output logic        Stall_MW,
  output logic [31:0] lsu_rdata,
  output logic        lsu_valid,
  output logic        lsu_buserr,
  output logic        lsu_misalign,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Last counter value of the REQ window: the abort fires in the
  // TIMEOUT_CYCLES-th request cycle if no ack has arrived.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        start_op;
  logic [1:0]  a_in;
  logic        is_byte_in;
  logic        is_half_in;
  logic [3:0]  be_fmt;
  logic [31:0] wdata_fmt;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  assign start_op   = mem_rd_MW | mem_wr_MW;
  assign a_in       = ALUResult_MW[1:0];
  assign is_byte_in = (funct3_MW == 3'b000) || (funct3_MW == 3'b100);
  assign is_half_in = (funct3_MW == 3'b001) || (funct3_MW == 3'b101);

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_q, mis_d;
  logic mis_in;
  // Halfwords need a[0]=0; anything that decodes as a word needs a=00.
  assign mis_in = (is_half_in & a_in[0]) |
                  (~is_half_in & ~is_byte_in & (a_in != 2'b00));
`endif

  // Store formatting: lane-replicated data, enables select the lanes.
  // Loads always read the full word and extract afterwards.
  always_comb begin
    be_fmt    = 4'b1111;
    wdata_fmt = rdata2_MW;
    if (is_byte_in) begin
      be_fmt    = 4'b0001 << a_in;
      wdata_fmt = {4{rdata2_MW[7:0]}};
    end else if (is_half_in) begin
      be_fmt    = a_in[1] ? 4'b1100 : 4'b0011;
      wdata_fmt = {2{rdata2_MW[15:0]}};
    end
    if (mem_rd_MW) begin
      be_fmt = 4'b1111;
    end
  end

  // Load extraction from the latched lane and access type.
  always_comb begin
    byte_sel = dbus_rdata[{lane_q, 3'b000} +: 8];
    half_sel = lane_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
    case (f3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = dbus_rdata;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    lane_d  = lane_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef LSU_MISALIGN_TRAP_EN
    mis_d   = mis_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_op) begin
          we_d    = mem_wr_MW;
          addr_d  = {ALUResult_MW[31:2], 2'b00};
          be_d    = be_fmt;
          wdata_d = wdata_fmt;
          f3_d    = funct3_MW;
          lane_d  = a_in;
          cnt_d   = 16'd0;
          err_d   = 1'b0;
          state_d = S_REQ;
`ifdef LSU_MISALIGN_TRAP_EN
          mis_d = 1'b0;
          if (mis_in) begin
            // Trap without touching the bus.
            mis_d   = 1'b1;
            rdata_d = 32'd0;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_REQ: begin
        if (dbus_ack) begin
          rdata_d = we_q ? 32'd0 : load_ext;
          state_d = S_DONE;
        end else if (cnt_q == TO_LAST) begin
          rdata_d = 32'd0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        // The MW register advances at the end of this cycle, so a held op
        // seen in IDLE next cycle is a new instruction.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      f3_q    <= 3'd0;
      lane_q  <= 2'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      lane_q  <= lane_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end
  assign lsu_misalign = (state_q == S_DONE) & mis_q;
`else
  assign lsu_misalign = 1'b0;
`endif

  assign Stall_MW   = ((state_q == S_IDLE) & start_op) | (state_q == S_REQ);
  assign lsu_valid  = (state_q == S_DONE);
  assign lsu_buserr = (state_q == S_DONE) & err_q;
  assign lsu_rdata  = rdata_q;

  // Bus outputs come straight from registers, so they are stable in REQ.
  assign dbus_req   = (state_q == S_REQ);
  assign dbus_we    = we_q;
  assign dbus_addr  = addr_q;
  assign dbus_be    = be_q;
  assign dbus_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_mw.sv
// ---------------------------------------------------------------------------
// tb_lsu_mw -- self-checking bench for lsu_mw (TIMEOUT_CYCLES=4).
// Directed table vectors, hand-written reset/timeout/ignored-ack sequences,
// then randomized back-to-back traffic checked against a behavioural model.
// ---------------------------------------------------------------------------
module tb_lsu_mw;

  localparam int TO = 4;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rd_MW, mem_wr_MW;
  logic [2:0]  funct3_MW;
  logic [31:0] ALUResult_MW, rdata2_MW;
  logic        Stall_MW;
  logic [31:0] lsu_rdata;
  logic        lsu_valid, lsu_buserr, lsu_misalign;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;

  lsu_mw #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_rd_MW    (mem_rd_MW),
    .mem_wr_MW    (mem_wr_MW),
    .funct3_MW    (funct3_MW),
    .ALUResult_MW (ALUResult_MW),
    .rdata2_MW    (rdata2_MW),
    .Stall_MW     (Stall_MW),
    .lsu_rdata    (lsu_rdata),
    .lsu_valid    (lsu_valid),
    .lsu_buserr   (lsu_buserr),
    .lsu_misalign (lsu_misalign),
    .dbus_req     (dbus_req),
    .dbus_we      (dbus_we),
    .dbus_addr    (dbus_addr),
    .dbus_be      (dbus_be),
    .dbus_wdata   (dbus_wdata),
    .dbus_ack     (dbus_ack),
    .dbus_rdata   (dbus_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int txn   = 0;

  // Observations from the last run_op call.
  logic [31:0] obs_rdata, obs_addr, obs_wdata;
  logic [3:0]  obs_be;
  logic        obs_we, obs_err, obs_mis, obs_got, obs_stall_done;
  int          obs_stall, obs_reqc, obs_unstable;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Presents one op at the next cycle, acts as bus slave, returns in DONE.
  // wait_n = number of REQ cycles before ack (-1 = never ack).
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data,
                        input int wait_n, input logic [31:0] word);
    obs_got = 0; obs_stall = 0; obs_reqc = 0; obs_unstable = 0;
    obs_rdata = '0; obs_err = 0; obs_mis = 0; obs_stall_done = 1'b1;
    obs_addr = '0; obs_be = '0; obs_wdata = '0; obs_we = 0;
    @(posedge clk); #1;
    mem_rd_MW = rd; mem_wr_MW = wr; funct3_MW = f3;
    ALUResult_MW = addr; rdata2_MW = data; dbus_ack = 0;
    #1;
    for (int cyc = 0; cyc < TO + 10; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
      end
      if (lsu_valid) begin
        obs_got = 1; obs_rdata = lsu_rdata; obs_err = lsu_buserr;
        obs_mis = lsu_misalign; obs_stall_done = Stall_MW;
        dbus_ack = 0;
        break;
      end
      if (Stall_MW) obs_stall++;
      if (dbus_req) begin
        if (obs_reqc == 0) begin
          obs_addr = dbus_addr; obs_be = dbus_be; obs_wdata = dbus_wdata; obs_we = dbus_we;
        end else if (obs_addr !== dbus_addr || obs_be !== dbus_be ||
                     obs_wdata !== dbus_wdata || obs_we !== dbus_we) begin
          obs_unstable++;
        end
        dbus_ack = (obs_reqc == wait_n);
        dbus_rdata = word;
        obs_reqc++;
      end else begin
        dbus_ack = 0;
      end
    end
  endtask

  // Behavioural reference: latency and results from plain arithmetic.
  task automatic do_check(input string tag, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] data, input int wait_n,
                          input logic [31:0] word);
    bit is_b, is_h, sgn, mis, tmo;
    int sh, e_reqc;
    logic [31:0] v, e_rdata, e_wd;
    logic [3:0] e_be;
    is_b = (f3 == 3'd0) || (f3 == 3'd4);
    is_h = (f3 == 3'd1) || (f3 == 3'd5);
    sgn  = (f3 == 3'd0) || (f3 == 3'd1);
    mis  = MIS_EN && ((is_h && addr[0]) || (!is_h && !is_b && addr[1:0] != 2'b00));
    tmo  = !mis && (wait_n < 0 || wait_n >= TO);
    e_reqc = mis ? 0 : (tmo ? TO : wait_n + 1);
    if (is_b) begin
      sh = 8 * int'(addr[1:0]);
      v = (word >> sh) & 32'hFF;
      if (sgn && v >= 32'h80) v = v - 32'h100;
    end else if (is_h) begin
      sh = addr[1] ? 16 : 0;
      v = (word >> sh) & 32'hFFFF;
      if (sgn && v >= 32'h8000) v = v - 32'h10000;
    end else begin
      v = word;
    end
    e_rdata = (mis || tmo || wr) ? 32'd0 : v;
    if (rd) begin
      e_be = 4'hF; e_wd = 32'd0;
    end else if (is_b) begin
      e_be = 4'(1 << addr[1:0]); e_wd = {24'd0, data[7:0]} * 32'h01010101;
    end else if (is_h) begin
      e_be = 4'(3 << (addr[1:0] & 2'b10)); e_wd = {16'd0, data[15:0]} * 32'h00010001;
    end else begin
      e_be = 4'hF; e_wd = data;
    end
    run_op(rd, wr, f3, addr, data, wait_n, word);
    txn++;
    $display("txn %0d %s: %s f3=%0d addr=%h wait=%0d -> rdata=%h err=%0d mis=%0d stall=%0d req=%0d",
             txn, tag, wr ? "ST" : "LD", f3, addr, wait_n, obs_rdata, obs_err, obs_mis,
             obs_stall, obs_reqc);
    chk({tag, " valid"}, 32'(obs_got), 32'd1);
    chk({tag, " rdata"}, obs_rdata, e_rdata);
    chk({tag, " buserr"}, 32'(obs_err), 32'(tmo));
    chk({tag, " misalign"}, 32'(obs_mis), 32'(mis));
    chk({tag, " stall_cycles"}, 32'(obs_stall), 32'(1 + e_reqc));
    chk({tag, " req_cycles"}, 32'(obs_reqc), 32'(e_reqc));
    chk({tag, " stall_in_done"}, 32'(obs_stall_done), 32'd0);
    if (e_reqc > 0) begin
      chk({tag, " addr"}, obs_addr, addr & 32'hFFFF_FFFC);
      chk({tag, " be"}, 32'(obs_be), 32'(e_be));
      chk({tag, " we"}, 32'(obs_we), 32'(wr));
      chk({tag, " bus_stable"}, 32'(obs_unstable), 32'd0);
      if (wr) chk({tag, " wdata"}, obs_wdata, e_wd);
    end
  endtask

  task automatic go_idle();
    @(posedge clk); #1;
    mem_rd_MW = 0; mem_wr_MW = 0; dbus_ack = 0;
    funct3_MW = 3'($urandom_range(0, 7)); ALUResult_MW = $urandom;
    #1;
    chk("nonmem_stall", 32'(Stall_MW), 32'd0);
  endtask

  typedef struct {
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, data;
    int          wait_n;
    logic [31:0] word, exp_rdata;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vt[9];

  initial begin
    rst = 1; mem_rd_MW = 0; mem_wr_MW = 0; funct3_MW = 0; ALUResult_MW = 0;
    rdata2_MW = 0; dbus_ack = 0; dbus_rdata = 0;

    vt[0] = '{0, 1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 32'h0, 32'h0, 4'hF, 32'hDEADBEEF};
    vt[1] = '{1, 0, 3'd0, 32'h203, 32'h0, 0, 32'h80FF_0000, 32'hFFFF_FF80, 4'hF, 32'h0};
    vt[2] = '{1, 0, 3'd4, 32'h203, 32'h0, 1, 32'h80FF_0000, 32'h0000_0080, 4'hF, 32'h0};
    vt[3] = '{1, 0, 3'd1, 32'h202, 32'h0, 0, 32'h80FF_0000, 32'hFFFF_80FF, 4'hF, 32'h0};
    vt[4] = '{0, 1, 3'd0, 32'h1, 32'h1234_56AB, 0, 32'h0, 32'h0, 4'b0010, 32'hABAB_ABAB};
    vt[5] = '{0, 1, 3'd1, 32'h2, 32'h0000_CAFE, 2, 32'h0, 32'h0, 4'b1100, 32'hCAFE_CAFE};
    vt[6] = '{1, 0, 3'd2, 32'h104, 32'h0, 3, 32'h1234_5678, 32'h1234_5678, 4'hF, 32'h0};
    vt[7] = '{1, 0, 3'd5, 32'h200, 32'h0, 0, 32'h80FF_8001, 32'h0000_8001, 4'hF, 32'h0};
    vt[8] = '{1, 0, 3'd3, 32'h108, 32'h0, 0, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 4'hF, 32'h0};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(dbus_req), 32'd0);
    chk("rst_valid", 32'(lsu_valid), 32'd0);
    chk("rst_stall", 32'(Stall_MW), 32'd0);
    chk("rst_flags", {30'd0, lsu_buserr, lsu_misalign}, 32'd0);
    chk("rst_rdata", lsu_rdata, 32'd0);
    chk("rst_bus", {27'd0, dbus_we, dbus_be} | dbus_addr | dbus_wdata, 32'd0);
    rst = 0;

    // Directed table, back-to-back (no idle between entries).
    foreach (vt[i]) begin
      do_check($sformatf("tab%0d", i), vt[i].rd, vt[i].wr, vt[i].f3, vt[i].addr,
               vt[i].data, vt[i].wait_n, vt[i].word);
      chk($sformatf("tab%0d tbl_rdata", i), obs_rdata, vt[i].exp_rdata);
      chk($sformatf("tab%0d tbl_be", i), 32'(obs_be), 32'(vt[i].exp_be));
      if (vt[i].wr) chk($sformatf("tab%0d tbl_wdata", i), obs_wdata, vt[i].exp_wdata);
    end
    go_idle();

    // Timeout, then a late ack with no op must be ignored.
    do_check("timeout", 1, 0, 3'd2, 32'h400, 32'h0, -1, 32'h1111_2222);
    chk("timeout_rdata", obs_rdata, 32'd0);
    chk("timeout_req", 32'(obs_reqc), 32'(TO));
    @(posedge clk); #1;
    mem_rd_MW = 0; mem_wr_MW = 0;
    begin
      int stray;
      stray = 0;
      for (int k = 0; k < 5; k++) begin
        dbus_ack = 1;
        @(posedge clk); #1;
        if (lsu_valid || dbus_req || Stall_MW) stray++;
      end
      dbus_ack = 0;
      chk("late_ack_ignored", 32'(stray), 32'd0);
    end

    // Reset in the second REQ cycle abandons the access.
    @(posedge clk); #1;
    mem_rd_MW = 1; funct3_MW = 3'd2; ALUResult_MW = 32'h300; dbus_ack = 0;
    @(posedge clk); #1;
    chk("rstmid_req1", 32'(dbus_req), 32'd1);
    @(posedge clk); #1;
    chk("rstmid_req2", 32'(dbus_req), 32'd1);
    rst = 1; mem_rd_MW = 0;
    @(posedge clk); #1;
    rst = 0;
    chk("rstmid_req_drop", 32'(dbus_req), 32'd0);
    chk("rstmid_stall", 32'(Stall_MW), 32'd0);
    begin
      int vcount;
      vcount = 0;
      for (int k = 0; k < 4; k++) begin
        if (lsu_valid) vcount++;
        @(posedge clk); #1;
      end
      chk("rstmid_no_valid", 32'(vcount), 32'd0);
    end
    do_check("after_rst_lw", 1, 0, 3'd2, 32'h300, 32'h0, 0, 32'hCAFE_F00D);
    go_idle();

    // Misaligned LW: traps with the macro, reads word 0x100 without.
    do_check("lw_0x101", 1, 0, 3'd2, 32'h101, 32'h0, 0, 32'hAABB_CCDD);
    go_idle();

    // Randomized traffic, mixed back-to-back and idle gaps.
    for (int n = 0; n < 80; n++) begin
      logic rd;
      logic [2:0] f3;
      int w;
      rd = 1'($urandom_range(0, 1));
      if (rd) begin
        case ($urandom_range(0, 6))
          0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4;
          4: f3 = 3'd5; 5: f3 = 3'd6; default: f3 = 3'd2;
        endcase
      end else begin
        f3 = 3'($urandom_range(0, 2));
      end
      w = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 5));
      do_check($sformatf("rnd%0d", n), rd, !rd, f3, $urandom, $urandom, w, $urandom);
      if ($urandom_range(0, 3) == 0) go_idle();
    end
    go_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
